// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM power-up initialisation sequencer.
package sdram_pkg;

   localparam int ADDR_W = 13;
   localparam int BA_W   = 2;

   // Command encodings as {cs_n, ras_n, cas_n, we_n}
   typedef logic [3:0] cmd_t;
   localparam cmd_t CMD_INHIBIT   = 4'b1111;
   localparam cmd_t CMD_PRECHARGE = 4'b0010;
   localparam cmd_t CMD_REFRESH   = 4'b0001;
   localparam cmd_t CMD_LOAD_MODE = 4'b0000;

   typedef enum logic [2:0] {
      PWR_WAIT,
      PRECHARGE,
      TRP_WAIT,
      REFRESH,
      TRFC_WAIT,
      LMR,
      TMRD_WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/sdram_cyc_timer.sv
// Loadable 16-bit down-counter used for the command spacing waits.
// It stops at zero and never wraps; zero_o flags an expired wait.
module sdram_cyc_timer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   output logic        zero_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Load takes priority; otherwise count down until zero and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != 16'd0) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   // Counter register, cleared by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM initialisation sequencer: power-up wait, PRECHARGE ALL, a burst of
// AUTO REFRESH commands, LOAD MODE, then holds init_done until reset or reinit.
// Outputs are registered from the next state, so the value seen after an edge
// always belongs to the state entered on that edge.
module sdram_init_seq
   import sdram_pkg::*;
#(
   parameter int PWR_UP_CYC = 2,
   parameter int TRP_CYC    = 3,
   parameter int TRFC_CYC   = 8,
   parameter int NUM_REF    = 8,
   parameter int TMRD_CYC   = 2
) (
   input  logic              sdram_clk,
   input  logic              sdram_resetn,
   input  logic [ADDR_W-1:0] cfg_mode_reg,
   input  logic              cfg_reinit,
   output logic              sdr_cke,
   output logic              sdr_cs_n,
   output logic              sdr_ras_n,
   output logic              sdr_cas_n,
   output logic              sdr_we_n,
   output logic [ADDR_W-1:0] sdr_addr,
   output logic [BA_W-1:0]   sdr_ba,
   output logic              sdr_init_done
);

   // Timer load values are "remaining cycles after the first one in the state".
   localparam logic [15:0] PWR_LOAD  = 16'(PWR_UP_CYC - 1);
   localparam logic [15:0] TRP_LOAD  = (TRP_CYC  >= 2) ? 16'(TRP_CYC  - 2) : 16'd0;
   localparam logic [15:0] TRFC_LOAD = (TRFC_CYC >= 2) ? 16'(TRFC_CYC - 2) : 16'd0;
   localparam logic [15:0] TMRD_LOAD = (TMRD_CYC >= 2) ? 16'(TMRD_CYC - 2) : 16'd0;
   localparam logic [15:0] REF_LAST  = 16'(NUM_REF);

   state_t            state_q, state_d;
   logic [15:0]       ref_q, ref_d;
   logic              cke_q;
   cmd_t              cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BA_W-1:0]   ba_q, ba_d;
   logic              done_q, done_d;
   logic              tmr_load;
   logic [15:0]       tmr_val;
   logic              tmr_zero;

   sdram_cyc_timer u_timer (
      .clk_i      (sdram_clk),
      .rst_ni     (sdram_resetn),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Next-state logic; cke_q low marks the first edge after reset, where the
   // power-up wait is armed so PWR_WAIT spans exactly PWR_UP_CYC output cycles.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      ref_d    = ref_q;
      if (!cke_q) begin
         state_d  = PWR_WAIT;
         tmr_load = 1'b1;
         tmr_val  = PWR_LOAD;
      end else begin
         case (state_q)
            PWR_WAIT: begin
               if (tmr_zero) state_d = PRECHARGE;
            end
            PRECHARGE: begin
               if (TRP_CYC == 1) begin
                  state_d = REFRESH;
               end else begin
                  state_d  = TRP_WAIT;
                  tmr_load = 1'b1;
                  tmr_val  = TRP_LOAD;
               end
            end
            TRP_WAIT: begin
               if (tmr_zero) state_d = REFRESH;
            end
            REFRESH: begin
               if (TRFC_CYC != 1) begin
                  state_d  = TRFC_WAIT;
                  tmr_load = 1'b1;
                  tmr_val  = TRFC_LOAD;
               end else if (ref_q == REF_LAST) begin
                  state_d = LMR;
               end else begin
                  state_d = REFRESH;
               end
            end
            TRFC_WAIT: begin
               if (tmr_zero) state_d = (ref_q == REF_LAST) ? LMR : REFRESH;
            end
            LMR: begin
               if (TMRD_CYC == 1) begin
                  state_d = DONE;
               end else begin
                  state_d  = TMRD_WAIT;
                  tmr_load = 1'b1;
                  tmr_val  = TMRD_LOAD;
               end
            end
            TMRD_WAIT: begin
               if (tmr_zero) state_d = DONE;
            end
            DONE: begin
               if (cfg_reinit) state_d = PRECHARGE;
            end
            default: state_d = PWR_WAIT;
         endcase
      end
      if (state_d == REFRESH) begin
         ref_d = ref_q + 16'd1;
      end else if (state_d == PRECHARGE) begin
         ref_d = '0;
      end
   end

   // Output decode from the state being entered, so pins are registered.
   always_comb begin
      cmd_d  = CMD_INHIBIT;
      addr_d = '0;
      ba_d   = '0;
      done_d = (state_d == DONE);
      case (state_d)
         PRECHARGE: begin
            cmd_d      = CMD_PRECHARGE;
            addr_d[10] = 1'b1;
         end
         REFRESH: cmd_d = CMD_REFRESH;
         LMR: begin
            cmd_d  = CMD_LOAD_MODE;
            addr_d = cfg_mode_reg;
         end
         default: cmd_d = CMD_INHIBIT;
      endcase
   end

   // State, refresh count and output registers with asynchronous reset.
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state_q <= PWR_WAIT;
         ref_q   <= '0;
         cke_q   <= 1'b0;
         cmd_q   <= CMD_INHIBIT;
         addr_q  <= '0;
         ba_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         cke_q   <= 1'b1;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         done_q  <= done_d;
      end
   end

   assign sdr_cke       = cke_q;
   assign sdr_cs_n      = cmd_q[3];
   assign sdr_ras_n     = cmd_q[2];
   assign sdr_cas_n     = cmd_q[1];
   assign sdr_we_n      = cmd_q[0];
   assign sdr_addr      = addr_q;
   assign sdr_ba        = ba_q;
   assign sdr_init_done = done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for the SDRAM initialisation sequencer: default timing,
// reinit in and outside DONE, asynchronous reset and an all-ones timing build.
module tb_sdram_init_seq;

   localparam logic [3:0] INH = 4'b1111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] LMD = 4'b0000;

   logic        clock = 1'b0;
   logic        resetN;
   logic [12:0] cfgModeReg;
   logic        cfgReinit;

   logic        cke, csN, rasN, casN, weN, initDone;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic        cke2, csN2, rasN2, casN2, weN2, initDone2;
   logic [12:0] addr2;
   logic [1:0]  ba2;

   logic [3:0] cmd, cmd2;
   assign cmd  = {csN, rasN, casN, weN};
   assign cmd2 = {csN2, rasN2, casN2, weN2};

   int checks = 0;
   int errors = 0;
   int preCount = 0;
   int refCount = 0;
   int lmrCount = 0;

   sdram_init_seq dut (
      .sdram_clk     (clock),
      .sdram_resetn  (resetN),
      .cfg_mode_reg  (cfgModeReg),
      .cfg_reinit    (cfgReinit),
      .sdr_cke       (cke),
      .sdr_cs_n      (csN),
      .sdr_ras_n     (rasN),
      .sdr_cas_n     (casN),
      .sdr_we_n      (weN),
      .sdr_addr      (addr),
      .sdr_ba        (ba),
      .sdr_init_done (initDone)
   );

   sdram_init_seq #(
      .PWR_UP_CYC (1),
      .TRP_CYC    (1),
      .TRFC_CYC   (1),
      .NUM_REF    (1),
      .TMRD_CYC   (1)
   ) dutFast (
      .sdram_clk     (clock),
      .sdram_resetn  (resetN),
      .cfg_mode_reg  (cfgModeReg),
      .cfg_reinit    (cfgReinit),
      .sdr_cke       (cke2),
      .sdr_cs_n      (csN2),
      .sdr_ras_n     (rasN2),
      .sdr_cas_n     (casN2),
      .sdr_we_n      (weN2),
      .sdr_addr      (addr2),
      .sdr_ba        (ba2),
      .sdr_init_done (initDone2)
   );

   // 10 time-unit clock
   always #5 clock = ~clock;

   // Hand-derived command schedule for the default build, indexed by cycle.
   function automatic logic [3:0] expCmd(input int n);
      if (n == 3) return PRE;
      if (n >= 6 && n <= 62 && ((n - 6) % 8) == 0) return REF;
      if (n == 70) return LMD;
      return INH;
   endfunction

   // Hand-derived schedule for the all-ones build.
   function automatic logic [3:0] expCmdFast(input int n);
      if (n == 2) return PRE;
      if (n == 3) return REF;
      if (n == 4) return LMD;
      return INH;
   endfunction

   // Drive the reinit input, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic reinit);
      cfgReinit = reinit;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " cke"},  16'(cke), 16'd0);
      checkOutput({tag, " cmd"},  16'(cmd), 16'(INH));
      checkOutput({tag, " addr"}, 16'(addr), 16'd0);
      checkOutput({tag, " ba"},   16'(ba), 16'd0);
      checkOutput({tag, " done"}, 16'(initDone), 16'd0);
   endtask

   initial begin
      resetN     = 1'b0;
      cfgModeReg = 13'h033;
      cfgReinit  = 1'b0;
      #12;
      checkResetValues("reset");

      // Default sequence, with a reinit pulse sampled while in cycle 20.
      @(negedge clock);
      resetN = 1'b1;
      for (int n = 1; n <= 75; n++) begin
         applyStimulus((n == 21) ? 1'b1 : 1'b0);
         checkOutput($sformatf("seq cmd c%0d", n), 16'(cmd), 16'(expCmd(n)));
         checkOutput($sformatf("seq done c%0d", n), 16'(initDone), 16'(n >= 72));
         if (cmd == PRE) preCount++;
         if (cmd == REF) refCount++;
         if (cmd == LMD) lmrCount++;
         if (n == 1 || n == 40) checkOutput($sformatf("seq cke c%0d", n), 16'(cke), 16'd1);
         if (n == 3) checkOutput("pre addr10", 16'(addr[10]), 16'd1);
         if (n == 70) begin
            checkOutput("lmr addr", 16'(addr), 16'h033);
            checkOutput("lmr ba", 16'(ba), 16'd0);
         end
         if (n == 30 || n == 71) begin
            checkOutput($sformatf("idle addr c%0d", n), 16'(addr), 16'd0);
            checkOutput($sformatf("idle ba c%0d", n), 16'(ba), 16'd0);
         end
         if (n <= 6) begin
            checkOutput($sformatf("fast cmd c%0d", n), 16'(cmd2), 16'(expCmdFast(n)));
            checkOutput($sformatf("fast done c%0d", n), 16'(initDone2), 16'(n >= 5));
            if (n == 4) checkOutput("fast lmr addr", 16'(addr2), 16'h033);
         end
      end
      checkOutput("count precharge", 16'(preCount), 16'd1);
      checkOutput("count refresh", 16'(refCount), 16'd8);
      checkOutput("count loadmode", 16'(lmrCount), 16'd1);

      // Reinit from DONE: next cycle is PRECHARGE with done low.
      cfgModeReg = 13'h155;
      applyStimulus(1'b1);
      checkOutput("reinit cmd", 16'(cmd), 16'(PRE));
      checkOutput("reinit done", 16'(initDone), 16'd0);
      for (int k = 1; k <= 69; k++) begin
         applyStimulus(1'b0);
         checkOutput($sformatf("reinit done k%0d", k), 16'(initDone), 16'(k == 69));
         if (k < 69) checkOutput($sformatf("reinit cmd k%0d", k), 16'(cmd), 16'(expCmd(k + 3)));
         if (k == 67) checkOutput("reinit lmr addr", 16'(addr), 16'h155);
      end

      // Asynchronous reset in the middle of cycle 40.
      cfgModeReg = 13'h033;
      @(negedge clock);
      resetN = 1'b0;
      @(negedge clock);
      resetN = 1'b1;
      for (int n = 1; n <= 40; n++) applyStimulus(1'b0);
      #2;
      resetN = 1'b0;
      #1;
      checkResetValues("async reset");
      for (int h = 1; h <= 3; h++) begin
         applyStimulus(1'b0);
         checkOutput($sformatf("held reset cke h%0d", h), 16'(cke), 16'd0);
         checkOutput($sformatf("held reset cmd h%0d", h), 16'(cmd), 16'(INH));
      end
      @(negedge clock);
      resetN = 1'b1;
      for (int n = 1; n <= 72; n++) begin
         applyStimulus(1'b0);
         if (n <= 6) checkOutput($sformatf("restart cmd c%0d", n), 16'(cmd), 16'(expCmd(n)));
         if (n == 1) checkOutput("restart cke", 16'(cke), 16'd1);
         if (n == 71 || n == 72) checkOutput($sformatf("restart done c%0d", n), 16'(initDone), 16'(n == 72));
      end

      // Reset while in DONE clears everything without a clock edge.
      #2;
      resetN = 1'b0;
      #1;
      checkResetValues("reset in done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
